// File: rtl/impact_sram_pkg.sv
`default_nettype none
// ============================================================================
// Module  : impact_sram_pkg
// Brief   : Shared types, constants and helpers for impact_sram_1rw1r.
// Revision: 1.0
// ============================================================================
package impact_sram_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int c_BYTE_W = 8;
  localparam int c_RL_MIN = 1;
  localparam int c_RL_MAX = 2;

  // Even parity: the stored bit makes the XOR of all nine bits zero.
  function automatic logic even_parity(input logic [c_BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/impact_sram_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module  : impact_sram_rd_pipe
// Brief   : 1- or 2-stage read-data/valid output pipeline; data holds between reads.
// Revision: 1.0
// ============================================================================
module impact_sram_rd_pipe
  import impact_sram_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_v1;
  logic [WIDTH-1:0] r_d1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_d1 <= '0;
    end else begin
      r_v1 <= i_valid;
      if (i_valid) r_d1 <= i_data;
    end
  end

  generate
    if (LATENCY >= c_RL_MAX) begin : g_two_stage
      logic             r_v2;
      logic [WIDTH-1:0] r_d2;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_v2 <= 1'b0;
          r_d2 <= '0;
        end else begin
          r_v2 <= r_v1;
          if (r_v1) r_d2 <= r_d1;
        end
      end

      assign o_valid = r_v2;
      assign o_data  = r_d2;
    end else begin : g_one_stage
      assign o_valid = r_v1;
      assign o_data  = r_d1;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/impact_sram_1rw1r.sv
`default_nettype none
// ============================================================================
// Module  : impact_sram_1rw1r
// Brief   : Single-clock 1RW+1R SRAM with byte masks, post-reset clear and
//           write-first collision handling. Optional parity: IMPACT_SRAM_PARITY_EN.
// Revision: 1.0
// ============================================================================
module impact_sram_1rw1r
  import impact_sram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int RAM_DEPTH    = 1 << ADDR_WIDTH,
  parameter int READ_LATENCY = 1,
  parameter int NUM_BYTES    = DATA_WIDTH / 8
) (
  input  logic                  clk0,
  input  logic                  rstb0,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_BYTES-1:0]  wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  rvalid0,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  rvalid1,
  output logic                  collision,
  output logic                  ready
`ifdef IMPACT_SRAM_PARITY_EN
  ,
  output logic                  perr0,
  output logic                  perr1
`endif
);

`ifdef IMPACT_SRAM_PARITY_EN
  localparam int c_LANE_W = c_BYTE_W + 1;
  localparam int c_F0_W   = 1;
  localparam int c_F1_W   = 2;
`else
  localparam int c_LANE_W = c_BYTE_W;
  localparam int c_F0_W   = 0;
  localparam int c_F1_W   = 1;
`endif
  localparam int                    c_WORD_W = NUM_BYTES * c_LANE_W;
  localparam int                    c_IDX_W  = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   c_DEPTH  = (ADDR_WIDTH + 1)'(RAM_DEPTH);
  localparam logic [c_IDX_W-1:0]    c_LAST   = c_IDX_W'(RAM_DEPTH - 1);

  logic [c_WORD_W-1:0] r_mem [RAM_DEPTH];

  state_t              r_state, w_state_nxt;
  logic [c_IDX_W-1:0]  r_clr_ptr, w_ptr_nxt;
  logic                w_clr_we;

  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      r_state   <= ST_CLEAR;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_clr_ptr;
    w_clr_we    = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_clr_we  = 1'b1;
        w_ptr_nxt = r_clr_ptr + 1'b1;
        if (r_clr_ptr == c_LAST) w_state_nxt = ST_READY;
      end
      ST_READY: w_state_nxt = ST_READY;
      default:  w_state_nxt = ST_CLEAR;
    endcase
  end

  assign ready = (r_state == ST_READY);

  logic               w_in0, w_in1, w_wr0, w_rd0, w_rd1, w_coll;
  logic [c_IDX_W-1:0] w_idx0, w_idx1;

  assign w_in0  = ({1'b0, addr0} < c_DEPTH);
  assign w_in1  = ({1'b0, addr1} < c_DEPTH);
  assign w_idx0 = addr0[c_IDX_W-1:0];
  assign w_idx1 = addr1[c_IDX_W-1:0];
  assign w_wr0  = ready & ~csb0 & ~web0 & w_in0;
  assign w_rd0  = ready & ~csb0 & web0;
  assign w_rd1  = ready & ~csb1;
  assign w_coll = w_wr0 & w_rd1 & (addr0 == addr1);

  logic [c_WORD_W-1:0]   w_wr_word, w_rd0_word, w_rd1_word;
  logic [DATA_WIDTH-1:0] w_rd0_data, w_rd1_data;
`ifdef IMPACT_SRAM_PARITY_EN
  logic                  w_perr0, w_perr1;
`endif

  // Port 1 sees the freshly written lanes on a collision (write-first).
  always_comb begin
    w_wr_word  = '0;
    w_rd0_word = w_in0 ? r_mem[w_idx0] : '0;
    w_rd1_word = w_in1 ? r_mem[w_idx1] : '0;
    w_rd0_data = '0;
    w_rd1_data = '0;
`ifdef IMPACT_SRAM_PARITY_EN
    w_perr0    = 1'b0;
    w_perr1    = 1'b0;
`endif
    for (int i = 0; i < NUM_BYTES; i++) begin
`ifdef IMPACT_SRAM_PARITY_EN
      w_wr_word[i*c_LANE_W +: c_LANE_W] = {even_parity(din0[i*c_BYTE_W +: c_BYTE_W]),
                                           din0[i*c_BYTE_W +: c_BYTE_W]};
`else
      w_wr_word[i*c_LANE_W +: c_LANE_W] = din0[i*c_BYTE_W +: c_BYTE_W];
`endif
      if (w_coll && wmask0[i])
        w_rd1_word[i*c_LANE_W +: c_LANE_W] = w_wr_word[i*c_LANE_W +: c_LANE_W];
      w_rd0_data[i*c_BYTE_W +: c_BYTE_W] = w_rd0_word[i*c_LANE_W +: c_BYTE_W];
      w_rd1_data[i*c_BYTE_W +: c_BYTE_W] = w_rd1_word[i*c_LANE_W +: c_BYTE_W];
`ifdef IMPACT_SRAM_PARITY_EN
      w_perr0 = w_perr0 | (^w_rd0_word[i*c_LANE_W +: c_LANE_W]);
      w_perr1 = w_perr1 | (^w_rd1_word[i*c_LANE_W +: c_LANE_W]);
`endif
    end
  end

  // An all-zero word already carries correct even parity, so clear writes '0.
  always_ff @(posedge clk0) begin
    if (w_clr_we) begin
      r_mem[r_clr_ptr] <= '0;
    end else if (w_wr0) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (wmask0[i])
          r_mem[w_idx0][i*c_LANE_W +: c_LANE_W] <= w_wr_word[i*c_LANE_W +: c_LANE_W];
      end
    end
  end

  logic [DATA_WIDTH+c_F0_W-1:0] w_pipe0_in, w_pipe0_out;
  logic [DATA_WIDTH+c_F1_W-1:0] w_pipe1_in, w_pipe1_out;
  logic                         w_coll_q;

`ifdef IMPACT_SRAM_PARITY_EN
  logic w_perr0_q, w_perr1_q;
  assign w_pipe0_in                    = {w_perr0, w_rd0_data};
  assign w_pipe1_in                    = {w_perr1, w_coll, w_rd1_data};
  assign {w_perr0_q, dout0}            = w_pipe0_out;
  assign {w_perr1_q, w_coll_q, dout1}  = w_pipe1_out;
  assign perr0                         = rvalid0 & w_perr0_q;
  assign perr1                         = rvalid1 & w_perr1_q;
`else
  assign w_pipe0_in                    = w_rd0_data;
  assign w_pipe1_in                    = {w_coll, w_rd1_data};
  assign dout0                         = w_pipe0_out;
  assign {w_coll_q, dout1}             = w_pipe1_out;
`endif
  // Flags ride with the held data, so they are qualified by the valid pulse.
  assign collision = rvalid1 & w_coll_q;

  impact_sram_rd_pipe #(
    .WIDTH  (DATA_WIDTH + c_F0_W),
    .LATENCY(READ_LATENCY)
  ) u_rd_pipe0 (
    .clk    (clk0),
    .rst_n  (rstb0),
    .i_valid(w_rd0),
    .i_data (w_pipe0_in),
    .o_valid(rvalid0),
    .o_data (w_pipe0_out)
  );

  impact_sram_rd_pipe #(
    .WIDTH  (DATA_WIDTH + c_F1_W),
    .LATENCY(READ_LATENCY)
  ) u_rd_pipe1 (
    .clk    (clk0),
    .rst_n  (rstb0),
    .i_valid(w_rd1),
    .i_data (w_pipe1_in),
    .o_valid(rvalid1),
    .o_data (w_pipe1_out)
  );

endmodule
`default_nettype wire

// File: tb/tb_impact_sram_1rw1r.sv
`default_nettype none
// ============================================================================
// Module  : tb_impact_sram_1rw1r
// Brief   : Directed bench; DUT A = 16 words / latency 1, DUT B = 12 words / latency 2.
// Revision: 1.0
// ============================================================================
module tb_impact_sram_1rw1r;

  logic        clk0 = 1'b0;
  logic        rstb0, csb0, web0, csb1;
  logic [3:0]  wmask0, addr0, addr1;
  logic [31:0] din0;

  logic [31:0] dout0_a, dout1_a, dout0_b, dout1_b;
  logic        rv0_a, rv1_a, coll_a, ready_a;
  logic        rv0_b, rv1_b, coll_b, ready_b;
`ifdef IMPACT_SRAM_PARITY_EN
  logic        perr0_a, perr1_a, perr0_b, perr1_b;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_a [16];
  logic [31:0] m_b [12];

  always #5 clk0 = ~clk0;

  impact_sram_1rw1r #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .RAM_DEPTH(16), .READ_LATENCY(1)
  ) u_dut_a (
    .clk0(clk0), .rstb0(rstb0), .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0), .dout0(dout0_a), .rvalid0(rv0_a),
    .csb1(csb1), .addr1(addr1), .dout1(dout1_a), .rvalid1(rv1_a),
    .collision(coll_a), .ready(ready_a)
`ifdef IMPACT_SRAM_PARITY_EN
    , .perr0(perr0_a), .perr1(perr1_a)
`endif
  );

  impact_sram_1rw1r #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .RAM_DEPTH(12), .READ_LATENCY(2)
  ) u_dut_b (
    .clk0(clk0), .rstb0(rstb0), .csb0(csb0), .web0(web0), .wmask0(wmask0),
    .addr0(addr0), .din0(din0), .dout0(dout0_b), .rvalid0(rv0_b),
    .csb1(csb1), .addr1(addr1), .dout1(dout1_b), .rvalid1(rv1_b),
    .collision(coll_b), .ready(ready_b)
`ifdef IMPACT_SRAM_PARITY_EN
    , .perr0(perr0_b), .perr1(perr1_b)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  function automatic logic [31:0] exp_a(input int a);
    return m_a[a];
  endfunction

  function automatic logic [31:0] exp_b(input int a);
    return (a < 12) ? m_b[a] : 32'h0;
  endfunction

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
    tick();
    csb0 = 1'b1; web0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        m_a[a][i*8 +: 8] = d[i*8 +: 8];
        if (a < 4'd12) m_b[a][i*8 +: 8] = d[i*8 +: 8];
      end
    end
  endtask

  // Port 0 walks up, port 1 walks down, one read per cycle on each.
  task automatic stream(input int base, input int n);
    for (int t = 0; t < n + 2; t++) begin
      if (t < n) begin
        csb0 = 1'b0; web0 = 1'b1; addr0 = 4'(base + t);
        csb1 = 1'b0; addr1 = 4'(base + n - 1 - t);
      end else begin
        csb0 = 1'b1; csb1 = 1'b1;
      end
      tick();
      chk1("strm_rv0_a", rv0_a, (t < n));
      chk1("strm_rv1_a", rv1_a, (t < n));
      chk1("strm_coll_a", coll_a, 1'b0);
      if (t < n) begin
        chk("strm_d0_a", dout0_a, exp_a(base + t));
        chk("strm_d1_a", dout1_a, exp_a(base + n - 1 - t));
      end
      chk1("strm_rv0_b", rv0_b, (t >= 1 && t <= n));
      chk1("strm_rv1_b", rv1_b, (t >= 1 && t <= n));
      chk1("strm_coll_b", coll_b, 1'b0);
      if (t >= 1 && t <= n) begin
        chk("strm_d0_b", dout0_b, exp_b(base + t - 1));
        chk("strm_d1_b", dout1_b, exp_b(base + n - t));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt_a, cnt_b;
    rstb0 = 1'b0; csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1;
    wmask0 = 4'h0; addr0 = 4'h0; addr1 = 4'h0; din0 = 32'h0;
    for (int i = 0; i < 16; i++) m_a[i] = 32'h0;
    for (int i = 0; i < 12; i++) m_b[i] = 32'h0;

    // Reset state
    tick(); tick(); tick();
    chk("rst_d0_a", dout0_a, 32'h0);  chk("rst_d1_a", dout1_a, 32'h0);
    chk("rst_d0_b", dout0_b, 32'h0);  chk("rst_d1_b", dout1_b, 32'h0);
    chk1("rst_rv0_a", rv0_a, 1'b0);   chk1("rst_rv1_b", rv1_b, 1'b0);
    chk1("rst_coll_a", coll_a, 1'b0); chk1("rst_ready_a", ready_a, 1'b0);
    chk1("rst_ready_b", ready_b, 1'b0);

    // Clear duration equals RAM_DEPTH
    rstb0 = 1'b1;
    cnt_a = 0; cnt_b = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (cnt_b == 0 && ready_b) cnt_b = i;
      if (ready_a) begin
        cnt_a = i;
        break;
      end
    end
    chk("ready_cycles_a", cnt_a, 32'd16);
    chk("ready_cycles_b", cnt_b, 32'd12);

    stream(0, 16);

    // Byte-masked overwrite
    wr(4'd5, 32'hDEADBEEF, 4'b1111);
    wr(4'd5, 32'h11223344, 4'b0101);
    csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd5;
    tick();
    csb0 = 1'b1;
    chk1("mask_rv0_a", rv0_a, 1'b1);
    chk("mask_d0_a", dout0_a, 32'hDE22BE44);
    chk1("mask_rv0_b_early", rv0_b, 1'b0);
    tick();
    chk1("mask_rv0_a_off", rv0_a, 1'b0);
    chk("mask_d0_a_hold", dout0_a, 32'hDE22BE44);
    chk1("mask_rv0_b", rv0_b, 1'b1);
    chk("mask_d0_b", dout0_b, 32'hDE22BE44);

    // Write-first collision
    wr(4'd7, 32'h12345678, 4'b1111);
    csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd7; din0 = 32'hA5A5A5A5; wmask0 = 4'b0011;
    csb1 = 1'b0; addr1 = 4'd7;
    tick();
    csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1;
    m_a[7] = 32'h1234A5A5; m_b[7] = 32'h1234A5A5;
    chk1("coll_rv1_a", rv1_a, 1'b1);
    chk("coll_d1_a", dout1_a, 32'h1234A5A5);
    chk1("coll_flag_a", coll_a, 1'b1);
    chk1("coll_flag_b_early", coll_b, 1'b0);
    tick();
    chk1("coll_flag_a_off", coll_a, 1'b0);
    chk1("coll_rv1_b", rv1_b, 1'b1);
    chk("coll_d1_b", dout1_b, 32'h1234A5A5);
    chk1("coll_flag_b", coll_b, 1'b1);

    // Full-throughput reads over written data
    for (int i = 0; i < 8; i++) wr(4'(i), 32'h01010101 * (i + 1), 4'b1111);
    stream(0, 8);

    // Out-of-range for DUT B, in range for DUT A; zero mask is a no-op
    wr(4'd13, 32'hFFFFFFFF, 4'b1111);
    wr(4'd3, 32'hFFFFFFFF, 4'b0000);
    csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd13;
    tick();
    csb0 = 1'b1;
    chk1("oor_rv0_a", rv0_a, 1'b1);
    chk("oor_d0_a", dout0_a, 32'hFFFFFFFF);
    tick();
    chk1("oor_rv0_b", rv0_b, 1'b1);
    chk("oor_d0_b", dout0_b, 32'h00000000);
    chk("noop_model", m_a[3], 32'h04040404);
    stream(0, 16);

    // Reset with reads in flight
    csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd5; csb1 = 1'b0; addr1 = 4'd7;
    tick();
    rstb0 = 1'b0;
    #1;
    chk1("mid_rv0_a", rv0_a, 1'b0);  chk1("mid_rv1_a", rv1_a, 1'b0);
    chk1("mid_rv0_b", rv0_b, 1'b0);  chk1("mid_rv1_b", rv1_b, 1'b0);
    chk("mid_d0_a", dout0_a, 32'h0); chk("mid_d1_b", dout1_b, 32'h0);
    chk1("mid_ready_a", ready_a, 1'b0);
    tick();
    chk1("mid_rv0_b_held", rv0_b, 1'b0);
    // Requests during the clear must be ignored: port 0 writes, port 1 reads.
    csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd2; din0 = 32'hFFFFFFFF; wmask0 = 4'hF;
    csb1 = 1'b0; addr1 = 4'd2;
    rstb0 = 1'b1;
    cnt_a = 0; cnt_b = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 12) begin
        csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1;
      end
      if (i <= 16) chk1("clr_rv1_a", rv1_a, 1'b0);
      if (i <= 13) chk1("clr_rv1_b", rv1_b, 1'b0);
      if (cnt_b == 0 && ready_b) cnt_b = i;
      if (ready_a) begin
        cnt_a = i;
        break;
      end
    end
    chk("re_ready_cycles_a", cnt_a, 32'd16);
    chk("re_ready_cycles_b", cnt_b, 32'd12);
    for (int i = 0; i < 16; i++) m_a[i] = 32'h0;
    for (int i = 0; i < 12; i++) m_b[i] = 32'h0;
    stream(0, 16);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/impact_sram_1rw1r.md
Name: impact_sram_1rw1r

Overview:
- Parametrised single-clock 1RW+1R behavioural SRAM; successor to the fixed 1024x32 dual-clock OpenRAM model.
- Adds per-byte write masking, configurable read latency (1 or 2), explicit read-valid strobes, and deterministic held outputs (no X after the edge).
- Also adds a post-reset memory-clear sequencer and defined port-0-write/port-1-read collision behaviour.
- Sits behind the user-project bus glue as the on-chip scratch buffer.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 10, address width in bits.
- RAM_DEPTH, 1<<ADDR_WIDTH, number of words; may be less than 2^ADDR_WIDTH.
- READ_LATENCY, 1, cycles from an accepted read to dout/rvalid; legal values are 1 and 2.
- NUM_BYTES, DATA_WIDTH/8, derived byte-lane count; do not override.

Ports:
- clk0  in  1  single clock; all logic on its rising edge.
- rstb0  in  1  asynchronous active-low reset.
- csb0  in  1  port-0 active-low chip select.
- web0  in  1  port-0 active-low write enable.
- wmask0  in  NUM_BYTES  port-0 byte write mask; bit i enables din0[8i+7:8i].
- addr0  in  ADDR_WIDTH  port-0 address.
- din0  in  DATA_WIDTH  port-0 write data.
- dout0  out  DATA_WIDTH  port-0 read data.
- rvalid0  out  1  one-cycle pulse when dout0 updates.
- csb1  in  1  port-1 active-low chip select (read-only port).
- addr1  in  ADDR_WIDTH  port-1 address.
- dout1  out  DATA_WIDTH  port-1 read data.
- rvalid1  out  1  one-cycle pulse when dout1 updates.
- collision  out  1  pulse aligned with rvalid1 when that read hit a same-cycle port-0 write.
- ready  out  1  high once the clear sequence has completed.

Behaviour:
- Reset, while rstb0=0: FSM=CLEAR, clear pointer=0, dout0=dout1=0, rvalid0=rvalid1=0, collision=0, ready=0, pipeline stages=0. Memory contents are not touched asynchronously.
- FSM states:
  - CLEAR: writes 0 to mem[ptr] each cycle, then ptr++. When ptr==RAM_DEPTH-1 is written, go to READY. Duration is exactly RAM_DEPTH cycles after reset release.
  - READY: ready=1 from the first cycle in READY. The FSM stays in READY until the next reset.
- Requests while ready=0 are ignored entirely: no write, no rvalid.
- Port 0 write (ready, csb0=0, web0=0): at the edge, bytes with wmask0[i]=1 take din0; other bytes are unchanged. wmask0=0 is a legal no-op write.
- Port 0 read (ready, csb0=0, web0=1): read is sampled at edge N; dout0 is updated and rvalid0=1 after edge N+READY_LATENCY, i.e. N+READ_LATENCY.
- Port 1 read: same timing as port 0 read, on addr1.
- Back-to-back reads on every cycle are supported: full throughput on both ports.
- dout0/dout1 hold their last value when no read completes; rvalid is low in those cycles.
- Collision (port-0 write and port-1 read, same address, same edge): write-first. dout1 = new bytes for lanes where wmask0=1, old bytes for the rest. collision=1 in the same cycle as that rvalid1.
- Simultaneous port-0 and port-1 reads of the same address are legal and are not a collision.
- Address >= RAM_DEPTH: writes are dropped; reads complete normally (rvalid pulses) with data 0.
- Reset mid-operation: in-flight reads are discarded with no rvalid, and the clear restarts from address 0.

Optional Feature:
- Macro IMPACT_SRAM_PARITY_EN.
- Defined: each byte stores an extra even-parity bit, computed on write and on clear (clear stores correct parity). Outputs perr0 and perr1 (1 bit each) are added. Each pulses with its rvalid when any returned byte's parity mismatches, and resets to 0.
- Undefined: no parity storage and no perr ports.

Decomposition:
- Package impact_sram_pkg holds:
  - FSM state typedef (CLEAR, READY).
  - Byte-width constant (8).
  - Legal READ_LATENCY values.
  - Parity helper function.
- One sub-module, impact_sram_rd_pipe: 1- or 2-stage data/valid/flag output pipeline with reset. It is instantiated once per port.

Test Plan:
- Release reset with RAM_DEPTH=16 → ready rises exactly 16 cycles after rstb0 goes high. Reading addresses 0..15 then returns 0 on every one.
- Write 0xDEADBEEF @addr 5 with wmask0=4'b1111, then write 0x11223344 @5 with wmask0=4'b0101, then read @5 → dout0=0xDE22BE44. rvalid0 pulses 1 cycle later (READ_LATENCY=1) or 2 cycles later (READ_LATENCY=2).
- Port-0 write 0xA5A5A5A5 @7 (mask 4'b0011) and port-1 read @7 on the same edge, with old value 0x12345678 → dout1=0x1234A5A5 and collision=1 in the same cycle as rvalid1.
- Issue reads every cycle on both ports over addresses 0..7 → eight consecutive rvalid pulses per port with the correct data and no bubbles.
- With RAM_DEPTH=12, write 0xFFFFFFFF @13 then read @13 → read returns 0x00000000 with rvalid. Reads of 0..11 are unaffected.
- Assert rstb0 low for 1 cycle with reads in flight → no rvalid appears, dout0 and dout1 go to 0, ready goes low, and the clear sequence reruns.
